// File: rtl/phase_sched_pkg.sv
// Shared types and constants for the traffic phase scheduler: FSM states,
// sequencer table codes and approach indices.
package phase_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_OFFER = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_CLEAR = 3'd4
    } schedStateT;

    localparam logic [1:0] TBL_NN   = 2'd0;
    localparam logic [1:0] TBL_NS   = 2'd1;
    localparam logic [1:0] TBL_TV   = 2'd2;
    localparam logic [1:0] TBL_REST = 2'd3;

    localparam int APP_NN         = 0;
    localparam int APP_NS         = 1;
    localparam int APP_TV         = 2;
    localparam int NUM_APPROACHES = 3;

    // Round-robin successor over the three approaches.
    function automatic logic [1:0] nextApproach(input logic [1:0] app);
        return (app >= 2'd2) ? 2'd0 : app + 2'd1;
    endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Free-running divider that emits a one-cycle secTick every TICKS_PER_SEC clocks.
module sec_prescaler #(
    parameter int TICKS_PER_SEC = 10000
) (
    input  logic clk,
    input  logic reset,
    output logic secTick
);

    localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST_TICK = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] tickCount;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tickCount <= '0;
            secTick   <= 1'b0;
        end else begin
            if (tickCount == LAST_TICK) begin
                tickCount <= '0;
            end else begin
                tickCount <= tickCount + 1'b1;
            end
            secTick <= (tickCount == LAST_TICK);
        end
    end

endmodule

// File: rtl/phase_scheduler.sv
// Demand-driven phase scheduler: latches walk requests, arbitrates round-robin
// with starvation override, and times min/max green plus all-red clearance.
module phase_scheduler
    import phase_sched_pkg::*;
#(
    parameter int TICKS_PER_SEC = 10000,
    parameter int MIN_GREEN_SEC = 10,
    parameter int MAX_GREEN_SEC = 30,
    parameter int CLEAR_SEC     = 2,
    parameter int MAX_WAIT_SEC  = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trafficSensorNN,
    input  logic       trafficSensorNS,
    input  logic       trafficSensorTv,
    input  logic       walkRequestNN,
    input  logic       walkRequestNS,
    input  logic       walkRequestTv,
    input  logic       tableAck,
    input  logic       phaseDone,
    output logic [1:0] tableSel,
    output logic       tableValid,
    output logic       phaseEnd,
    output logic [2:0] walkPending,
    output logic [2:0] schedState
);

    logic        secTick;
    logic [2:0]  sensorRaw;
    logic [2:0]  walkReq;
    logic [2:0]  demand;
    logic [2:0]  starved;
    logic [2:0]  pendingVec;
    logic [2:0]  ackHit;
    logic [2:0]  grantHit;
    logic [2:0]  grantMask;
    logic [2:0]  candidates;
    logic [1:0]  winner;
    logic        endPhase;

    schedStateT  stateReg;
    logic [1:0]  tableSelReg;
    logic        tableValidReg;
    logic        phaseEndReg;
    logic [1:0]  lastGrant;
    logic [7:0]  elapsed;
    logic [7:0]  clrCount;

    sec_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) uPrescaler (
        .clk    (clk),
        .reset  (reset),
        .secTick(secTick)
    );

    assign sensorRaw = {trafficSensorTv, trafficSensorNS, trafficSensorNN};
    assign walkReq   = {walkRequestTv, walkRequestNS, walkRequestNN};
    assign grantMask = 3'b001 << lastGrant;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_APPROACHES; gi++) begin : gApproach
            logic       syncMeta;
            logic       syncOut;
            logic       pendReg;
            logic [7:0] waitReg;

            assign ackHit[gi]   = (stateReg == ST_OFFER) && tableAck && (tableSelReg == 2'(gi));
            assign grantHit[gi] = ((stateReg == ST_RUN) || (stateReg == ST_DRAIN)) && grantMask[gi];

            // Walk set beats the ack clear, so a press during the ack cycle is kept.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    syncMeta <= 1'b0;
                    syncOut  <= 1'b0;
                    pendReg  <= 1'b0;
                    waitReg  <= 8'd0;
                end else begin
                    syncMeta <= sensorRaw[gi];
                    syncOut  <= syncMeta;
                    if (walkReq[gi]) begin
                        pendReg <= 1'b1;
                    end else if (ackHit[gi]) begin
                        pendReg <= 1'b0;
                    end
                    if (ackHit[gi]) begin
                        waitReg <= 8'd0;
                    end else if (secTick && demand[gi] && !grantHit[gi] && (waitReg != 8'hFF)) begin
                        waitReg <= waitReg + 8'd1;
                    end
                end
            end

            assign pendingVec[gi] = pendReg;
            assign demand[gi]     = syncOut | pendReg;
            assign starved[gi]    = (waitReg >= 8'(MAX_WAIT_SEC));
        end
    endgenerate

    // Starved approaches pre-empt fairness; the search starts one past lastGrant.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        candidates = (|starved) ? starved : demand;
        winner     = lastGrant;
        idx        = lastGrant;
        found      = 1'b0;
        for (int k = 0; k < NUM_APPROACHES; k++) begin
            idx = nextApproach(idx);
            if (!found && candidates[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        endPhase = 1'b0;
        if (elapsed >= 8'(MAX_GREEN_SEC)) begin
            endPhase = 1'b1;
        end else if (elapsed >= 8'(MIN_GREEN_SEC)) begin
            endPhase = (|(demand & ~grantMask)) || !(|(demand & grantMask));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg      <= ST_IDLE;
            tableSelReg   <= TBL_REST;
            tableValidReg <= 1'b0;
            phaseEndReg   <= 1'b0;
            lastGrant     <= TBL_TV;
            elapsed       <= 8'd0;
            clrCount      <= 8'd0;
        end else begin
            phaseEndReg <= 1'b0;
            case (stateReg)
                ST_IDLE: begin
                    tableSelReg <= TBL_REST;
                    if (|demand) begin
                        tableSelReg   <= winner;
                        tableValidReg <= 1'b1;
                        stateReg      <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (tableAck) begin
                        lastGrant     <= tableSelReg;
                        elapsed       <= 8'd0;
                        tableValidReg <= 1'b0;
                        stateReg      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (endPhase) begin
                        phaseEndReg <= 1'b1;
                        stateReg    <= ST_DRAIN;
                    end else if (secTick && (elapsed != 8'hFF)) begin
                        elapsed <= elapsed + 8'd1;
                    end
                end
                ST_DRAIN: begin
                    if (phaseDone) begin
                        clrCount    <= 8'd0;
                        tableSelReg <= TBL_REST;
                        stateReg    <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (clrCount >= 8'(CLEAR_SEC)) begin
                        if (|demand) begin
                            tableSelReg   <= winner;
                            tableValidReg <= 1'b1;
                            stateReg      <= ST_OFFER;
                        end else begin
                            stateReg <= ST_IDLE;
                        end
                    end else if (secTick) begin
                        clrCount <= clrCount + 8'd1;
                    end
                end
                default: begin
                    stateReg      <= ST_IDLE;
                    tableSelReg   <= TBL_REST;
                    tableValidReg <= 1'b0;
                end
            endcase
        end
    end

    assign tableSel    = tableSelReg;
    assign tableValid  = tableValidReg;
    assign phaseEnd    = phaseEndReg;
    assign walkPending = pendingVec;
    assign schedState  = stateReg;

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed scenarios for phase_scheduler with a 10-cycle second; one task per feature.
module tb_phase_scheduler;
    import phase_sched_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       trafficSensorNN, trafficSensorNS, trafficSensorTv;
    logic       walkRequestNN, walkRequestNS, walkRequestTv;
    logic       tableAck, phaseDone;
    logic [1:0] tableSel;
    logic       tableValid, phaseEnd;
    logic [2:0] walkPending, schedState;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    phase_scheduler #(
        .TICKS_PER_SEC(10), .MIN_GREEN_SEC(10), .MAX_GREEN_SEC(30),
        .CLEAR_SEC(2), .MAX_WAIT_SEC(10)
    ) dut (
        .clk(clk), .reset(reset),
        .trafficSensorNN(trafficSensorNN), .trafficSensorNS(trafficSensorNS),
        .trafficSensorTv(trafficSensorTv),
        .walkRequestNN(walkRequestNN), .walkRequestNS(walkRequestNS),
        .walkRequestTv(walkRequestTv),
        .tableAck(tableAck), .phaseDone(phaseDone),
        .tableSel(tableSel), .tableValid(tableValid), .phaseEnd(phaseEnd),
        .walkPending(walkPending), .schedState(schedState)
    );

    task automatic applyReset();
        reset = 1'b0;
        {trafficSensorNN, trafficSensorNS, trafficSensorTv} = 3'b000;
        {walkRequestNN, walkRequestNS, walkRequestTv} = 3'b000;
        tableAck = 1'b0;
        phaseDone = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic waitForValid(input int limit, output int cycles, output bit ok);
        cycles = 0;
        ok = 1'b0;
        while (cycles < limit && !ok) begin
            @(negedge clk);
            cycles++;
            if (tableValid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic waitForPhaseEnd(input int limit, output int cycles, output bit ok);
        cycles = 0;
        ok = 1'b0;
        while (cycles < limit && !ok) begin
            @(negedge clk);
            cycles++;
            if (phaseEnd === 1'b1) ok = 1'b1;
        end
    endtask

    // Ack on the current negedge, then release it one cycle later.
    task automatic ackOffer();
        tableAck = 1'b1;
        @(negedge clk);
        tableAck = 1'b0;
    endtask

    task automatic pulseDone();
        phaseDone = 1'b1;
        @(negedge clk);
        phaseDone = 1'b0;
    endtask

    task automatic test_reset();
        int peCount;
        int tvCount;
        reset = 1'b0;
        {trafficSensorNN, trafficSensorNS, trafficSensorTv} = 3'b000;
        {walkRequestNN, walkRequestNS, walkRequestTv} = 3'b000;
        tableAck = 1'b0;
        phaseDone = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (tableSel !== 2'd3 || tableValid !== 1'b0 || phaseEnd !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: sel=%0d valid=%b end=%b, want sel=3 valid=0 end=0", tableSel, tableValid, phaseEnd);
        end
        vectors++;
        if (walkPending !== 3'b000 || schedState !== ST_IDLE) begin
            miscompares++;
            $display("FAIL reset_state: walk=%b state=%0d, want walk=000 state=0", walkPending, schedState);
        end
        reset = 1'b1;
        peCount = 0;
        tvCount = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (phaseEnd === 1'b1) peCount++;
            if (tableValid !== 1'b0) tvCount++;
        end
        vectors++;
        if (peCount !== 0) begin
            miscompares++;
            $display("FAIL idle_phase_end: pulses=%0d, want 0", peCount);
        end
        vectors++;
        if (tvCount !== 0) begin
            miscompares++;
            $display("FAIL idle_valid: cycles_valid=%0d, want 0", tvCount);
        end
        vectors++;
        if (tableSel !== 2'd3 || schedState !== ST_IDLE) begin
            miscompares++;
            $display("FAIL idle_final: sel=%0d state=%0d, want sel=3 state=0", tableSel, schedState);
        end
        $display("test_reset: sel=%0d valid=%b state=%0d after 200 idle cycles", tableSel, tableValid, schedState);
    endtask

    task automatic test_walk_latch();
        applyReset();
        walkRequestNN = 1'b1;
        @(negedge clk);
        walkRequestNN = 1'b0;
        vectors++;
        if (walkPending !== 3'b001 || tableValid !== 1'b0) begin
            miscompares++;
            $display("FAIL walk_latch: walk=%b valid=%b, want walk=001 valid=0", walkPending, tableValid);
        end
        @(negedge clk);
        vectors++;
        if (tableValid !== 1'b1 || tableSel !== 2'd0) begin
            miscompares++;
            $display("FAIL walk_offer: valid=%b sel=%0d, want valid=1 sel=0", tableValid, tableSel);
        end
        ackOffer();
        vectors++;
        if (walkPending !== 3'b000 || tableValid !== 1'b0 || schedState !== ST_RUN) begin
            miscompares++;
            $display("FAIL walk_ack: walk=%b valid=%b state=%0d, want walk=000 valid=0 state=2", walkPending, tableValid, schedState);
        end
        $display("test_walk_latch: granted sel=%0d, walk=%b after ack", tableSel, walkPending);
    endtask

    task automatic test_max_green();
        int cyc;
        bit ok;
        applyReset();
        trafficSensorTv = 1'b1;
        waitForValid(20, cyc, ok);
        vectors++;
        if (!ok || tableSel !== 2'd2) begin
            miscompares++;
            $display("FAIL max_first_grant: valid=%b sel=%0d, want valid=1 sel=2", tableValid, tableSel);
        end
        ackOffer();
        waitForPhaseEnd(400, cyc, ok);
        vectors++;
        if (!ok || cyc < 288 || cyc > 303) begin
            miscompares++;
            $display("FAIL max_green_end: seen=%b at cycle %0d, want pulse in 288..303", ok, cyc);
        end
        @(negedge clk);
        pulseDone();
        waitForValid(40, cyc, ok);
        vectors++;
        if (!ok || cyc < 10 || cyc > 22) begin
            miscompares++;
            $display("FAIL max_clear_time: seen=%b at cycle %0d, want valid in 10..22", ok, cyc);
        end
        vectors++;
        if (tableSel !== 2'd2) begin
            miscompares++;
            $display("FAIL max_regrant: sel=%0d, want 2", tableSel);
        end
        $display("test_max_green: lone Tv re-granted sel=%0d after %0d clear cycles", tableSel, cyc);
    endtask

    task automatic test_min_green_preempt();
        int cyc;
        int endAt;
        bit ok;
        applyReset();
        trafficSensorTv = 1'b1;
        waitForValid(20, cyc, ok);
        ackOffer();
        endAt = -1;
        for (int c = 1; c <= 200 && endAt < 0; c++) begin
            @(negedge clk);
            if (c == 30) trafficSensorNN = 1'b1;
            if (phaseEnd === 1'b1) endAt = c;
        end
        vectors++;
        if (endAt < 89 || endAt > 102) begin
            miscompares++;
            $display("FAIL min_green_end: cycle=%0d, want 89..102", endAt);
        end
        @(negedge clk);
        pulseDone();
        waitForValid(40, cyc, ok);
        vectors++;
        if (!ok || tableSel !== 2'd0) begin
            miscompares++;
            $display("FAIL min_next_grant: valid=%b sel=%0d, want valid=1 sel=0", tableValid, tableSel);
        end
        $display("test_min_green_preempt: phaseEnd at cycle %0d, next sel=%0d", endAt, tableSel);
    endtask

    task automatic test_round_robin();
        int cyc;
        bit ok;
        logic [1:0] expSeq [4];
        expSeq[0] = 2'd0;
        expSeq[1] = 2'd1;
        expSeq[2] = 2'd2;
        expSeq[3] = 2'd0;
        applyReset();
        {trafficSensorNN, trafficSensorNS, trafficSensorTv} = 3'b111;
        waitForValid(20, cyc, ok);
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (!ok || tableSel !== expSeq[k]) begin
                miscompares++;
                $display("FAIL rr_grant%0d: valid=%b sel=%0d, want valid=1 sel=%0d", k, tableValid, tableSel, expSeq[k]);
            end
            $display("test_round_robin: grant %0d sel=%0d", k, tableSel);
            if (k < 3) begin
                ackOffer();
                waitForPhaseEnd(400, cyc, ok);
                @(negedge clk);
                pulseDone();
                waitForValid(40, cyc, ok);
            end
        end
    endtask

    task automatic test_starvation();
        int cyc;
        int endAt;
        bit ok;
        applyReset();
        trafficSensorNN = 1'b1;
        waitForValid(20, cyc, ok);
        vectors++;
        if (!ok || tableSel !== 2'd0) begin
            miscompares++;
            $display("FAIL starve_first: valid=%b sel=%0d, want valid=1 sel=0", tableValid, tableSel);
        end
        walkRequestTv = 1'b1;
        @(negedge clk);
        walkRequestTv = 1'b0;
        ackOffer();
        endAt = -1;
        for (int c = 1; c <= 116; c++) begin
            @(negedge clk);
            if (c == 110) trafficSensorNS = 1'b1;
            if (c == 115) phaseDone = 1'b1;
            if (c == 116) phaseDone = 1'b0;
            if (phaseEnd === 1'b1 && endAt < 0) endAt = c;
        end
        vectors++;
        if (endAt < 89 || endAt > 102) begin
            miscompares++;
            $display("FAIL starve_nn_end: cycle=%0d, want 89..102", endAt);
        end
        waitForValid(40, cyc, ok);
        vectors++;
        if (!ok || tableSel !== 2'd2) begin
            miscompares++;
            $display("FAIL starve_override: valid=%b sel=%0d, want valid=1 sel=2", tableValid, tableSel);
        end
        vectors++;
        if (walkPending !== 3'b100) begin
            miscompares++;
            $display("FAIL starve_walk_held: walk=%b, want 100", walkPending);
        end
        ackOffer();
        vectors++;
        if (walkPending !== 3'b000) begin
            miscompares++;
            $display("FAIL starve_walk_clear: walk=%b, want 000", walkPending);
        end
        $display("test_starvation: NN ended at cycle %0d, starved Tv granted sel=%0d", endAt, tableSel);
    endtask

    task automatic test_async_reset();
        int cyc;
        bit ok;
        applyReset();
        trafficSensorTv = 1'b1;
        waitForValid(20, cyc, ok);
        ackOffer();
        repeat (20) @(negedge clk);
        walkRequestNS = 1'b1;
        @(negedge clk);
        walkRequestNS = 1'b0;
        vectors++;
        if (schedState !== ST_RUN || walkPending !== 3'b010 || tableSel !== 2'd2) begin
            miscompares++;
            $display("FAIL areset_setup: state=%0d walk=%b sel=%0d, want state=2 walk=010 sel=2", schedState, walkPending, tableSel);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (tableSel !== 2'd3 || phaseEnd !== 1'b0 || walkPending !== 3'b000) begin
            miscompares++;
            $display("FAIL areset_outputs: sel=%0d end=%b walk=%b, want sel=3 end=0 walk=000", tableSel, phaseEnd, walkPending);
        end
        vectors++;
        if (schedState !== ST_IDLE || tableValid !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_state: state=%0d valid=%b, want state=0 valid=0", schedState, tableValid);
        end
        $display("test_async_reset: mid-RUN reset gives sel=%0d state=%0d", tableSel, schedState);
        trafficSensorTv = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_walk_latch();
        test_max_green();
        test_min_green_preempt();
        test_round_robin();
        test_starvation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
